// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: BCD digits and display controls in, scanned segment/anode pins out.
// The driver takes the slave view; the digit source (or a bench) takes the master view.
interface seg7_scan_driver_if;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_zeros;
  logic [3:0] dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output thousands, hundreds, tens, ones, blank_zeros, dp_mask,
    input  seg, dp, an
  );

  modport slave (
    input  thousands, hundreds, tens, ones, blank_zeros, dp_mask,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame digit snapshots,
// leading-zero blanking, decimal points and anti-ghosting dead time.
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave io_disp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_shTh;
  logic [3:0]       r_shHu;
  logic [3:0]       r_shTe;
  logic [3:0]       r_shOn;
  logic             r_shBlank;
  logic [3:0]       r_shDp;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic       w_tick;
  logic       w_dead;
  logic [3:0] w_digit;
  logic [3:0] w_blank;
  logic [6:0] w_segRaw;
  logic [6:0] w_segNext;
  logic       w_dpNext;
  logic [3:0] w_anRaw;
  logic [3:0] w_anNext;

  function automatic logic [6:0] bcdToSeg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign w_tick = (r_cnt == CNT_LAST);

  generate
    if (DEAD_CYCLES == 0) begin : g_noDead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (32'(r_cnt) < 32'(DEAD_CYCLES));
    end
  endgenerate

  // A digit is blank only when every more-significant digit is also zero;
  // invalid codes compare nonzero, so they stop the blanking run.
  assign w_blank[3] = r_shBlank && (r_shTh == 4'd0);
  assign w_blank[2] = w_blank[3] && (r_shHu == 4'd0);
  assign w_blank[1] = w_blank[2] && (r_shTe == 4'd0);
  assign w_blank[0] = 1'b0;

  always_comb begin
    w_digit = r_shOn;
    case (r_idx)
      2'd0: w_digit = r_shOn;
      2'd1: w_digit = r_shTe;
      2'd2: w_digit = r_shHu;
      2'd3: w_digit = r_shTh;
      default: w_digit = r_shOn;
    endcase
  end

  always_comb begin
    w_segRaw  = w_blank[r_idx] ? 7'h00 : bcdToSeg(w_digit);
    w_segNext = SEG_ACTIVE_LOW ? ~w_segRaw : w_segRaw;
    w_dpNext  = SEG_ACTIVE_LOW ? ~r_shDp[r_idx] : r_shDp[r_idx];
    w_anRaw   = w_dead ? 4'h0 : (4'b0001 << r_idx);
    w_anNext  = AN_ACTIVE_LOW ? ~w_anRaw : w_anRaw;
  end

  // Shadow registers reload only at the 3->0 wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_shTh    <= 4'd0;
      r_shHu    <= 4'd0;
      r_shTe    <= 4'd0;
      r_shOn    <= 4'd0;
      r_shBlank <= 1'b0;
      r_shDp    <= 4'd0;
      r_seg     <= SEG_OFF;
      r_dp      <= DP_OFF;
      r_an      <= AN_OFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_shTh    <= io_disp.thousands;
          r_shHu    <= io_disp.hundreds;
          r_shTe    <= io_disp.tens;
          r_shOn    <= io_disp.ones;
          r_shBlank <= io_disp.blank_zeros;
          r_shDp    <= io_disp.dp_mask;
        end
      end
      r_seg <= w_segNext;
      r_dp  <= w_dpNext;
      r_an  <= w_anNext;
    end
  end

  assign io_disp.seg = r_seg;
  assign io_disp.dp  = r_dp;
  assign io_disp.an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-level reference model checked every cycle,
// plus directed scenarios with literal expected pin values.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg7_scan_driver_if dispIf ();

  seg7_scan_driver #(
    .REFRESH_DIV   (DIV),
    .DEAD_CYCLES   (DEAD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_disp(dispIf.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: position k since reset determines slot and frame;
  // the frame's digits are whatever the inputs were at the last edge of the previous frame.
  logic [6:0] glyph [16];
  logic [3:0] mDig [4];
  logic       mBz;
  logic [3:0] mDpm;
  int         mK = 0;
  bit         mValid = 1'b0;
  logic [6:0] expSeg;
  logic       expDp;
  logic [3:0] expAn;

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      expAn  = 4'hF;
      expSeg = 7'h7F;
      expDp  = 1'b1;
      mK     = 0;
      for (int j = 0; j < 4; j++) mDig[j] = 4'd0;
      mBz    = 1'b0;
      mDpm   = 4'd0;
      mValid = 1'b1;
    end else if (mValid) begin
      int slot;
      int pos;
      bit blank;
      pos  = mK % DIV;
      slot = (mK / DIV) % 4;
      blank = mBz && (slot != 0);
      for (int j = 3; j >= 0; j--) begin
        if (j >= slot && mDig[j] != 4'd0) blank = 1'b0;
      end
      expSeg = blank ? 7'h7F : ~glyph[mDig[slot]];
      expDp  = ~mDpm[slot];
      expAn  = (pos < DEAD) ? 4'hF : ~(4'(1) << slot);
      if (mK % FRAME == FRAME - 1) begin
        mDig[3] = dispIf.thousands;
        mDig[2] = dispIf.hundreds;
        mDig[1] = dispIf.tens;
        mDig[0] = dispIf.ones;
        mBz     = dispIf.blank_zeros;
        mDpm    = dispIf.dp_mask;
      end
      mK = mK + 1;
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      checks = checks + 3;
      if (dispIf.seg !== expSeg) begin
        failures = failures + 1;
        $display("[TB] FAIL model_seg k=%0d got=%h want=%h", mK, dispIf.seg, expSeg);
      end
      if (dispIf.an !== expAn) begin
        failures = failures + 1;
        $display("[TB] FAIL model_an k=%0d got=%b want=%b", mK, dispIf.an, expAn);
      end
      if (dispIf.dp !== expDp) begin
        failures = failures + 1;
        $display("[TB] FAIL model_dp k=%0d got=%b want=%b", mK, dispIf.dp, expDp);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] th, input logic [3:0] hu,
                               input logic [3:0] te, input logic [3:0] on,
                               input logic bz, input logic [3:0] dpm);
    dispIf.thousands   = th;
    dispIf.hundreds    = hu;
    dispIf.tens        = te;
    dispIf.ones        = on;
    dispIf.blank_zeros = bz;
    dispIf.dp_mask     = dpm;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp);
    checks = checks + 1;
    if (dispIf.an !== an || dispIf.seg !== seg || dispIf.dp !== dp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
               name, dispIf.an, dispIf.seg, dispIf.dp, an, seg, dp);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      failures = failures + 1;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called on a negedge; returns on the negedge where the outputs reflect position p.
  task automatic sampleAt(input string name, input int p);
    int budget = 400;
    while (mK != p + 1 && mK <= p && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (mK != p + 1) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("[TB] FAIL %s_reach got_k=%0d want_k=%0d", name, mK, p + 1);
    end
  endtask

  task automatic applyReset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    checkOutput("reset_state", 4'hF, 7'h7F, 1'b1);
  endtask

  initial begin
    int tally [5];
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    @(negedge clk);

    $display("[TB] scenario 1: basic scan");
    applyReset(3);
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd0);
    rst_n = 1'b1;
    sampleAt("f0_d0", 4);
    checkOutput("f0_d0_zero", 4'hE, 7'h40, 1'b1);
    sampleAt("f1_dead", 32);
    checkOutput("f1_dead_pattern", 4'hF, 7'h19, 1'b1);
    sampleAt("f1_d0", 36);
    checkOutput("f1_d0_four", 4'hE, 7'h19, 1'b1);
    sampleAt("f1_d1", 45);
    checkOutput("f1_d1_three", 4'hD, 7'h30, 1'b1);
    sampleAt("f1_d2", 51);
    checkOutput("f1_d2_two", 4'hB, 7'h24, 1'b1);
    sampleAt("f1_d3", 63);
    checkOutput("f1_d3_one", 4'h7, 7'h79, 1'b1);

    $display("[TB] scenario 2: dead time and period");
    sampleAt("f2_start", 64);
    for (int j = 0; j < 5; j++) tally[j] = 0;
    for (int i = 0; i < FRAME; i++) begin
      case (dispIf.an)
        4'hF: tally[4]++;
        4'hE: tally[0]++;
        4'hD: tally[1]++;
        4'hB: tally[2]++;
        4'h7: tally[3]++;
        default: ;
      endcase
      @(negedge clk);
    end
    checkCount("dead_cycles_per_frame", tally[4], 4 * DEAD);
    checkCount("an0_active", tally[0], DIV - DEAD);
    checkCount("an1_active", tally[1], DIV - DEAD);
    checkCount("an2_active", tally[2], DIV - DEAD);
    checkCount("an3_active", tally[3], DIV - DEAD);

    $display("[TB] scenario 3: leading-zero blanking");
    applyReset(2);
    applyStimulus(4'd0, 4'd0, 4'd7, 4'd0, 1'b1, 4'd0);
    rst_n = 1'b1;
    sampleAt("blk_d0", 36);
    checkOutput("blk_d0", 4'hE, 7'h40, 1'b1);
    sampleAt("blk_d1", 44);
    checkOutput("blk_d1_seven", 4'hD, 7'h78, 1'b1);
    sampleAt("blk_d2", 52);
    checkOutput("blk_d2_off", 4'hB, 7'h7F, 1'b1);
    sampleAt("blk_d3", 60);
    checkOutput("blk_d3_off", 4'h7, 7'h7F, 1'b1);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0);
    sampleAt("zero_d0", 68);
    checkOutput("zero_d0_lit", 4'hE, 7'h40, 1'b1);
    sampleAt("zero_d1", 76);
    checkOutput("zero_d1_off", 4'hD, 7'h7F, 1'b1);
    sampleAt("zero_d3", 92);
    checkOutput("zero_d3_off", 4'h7, 7'h7F, 1'b1);

    $display("[TB] scenario 4: frame coherence");
    applyReset(2);
    applyStimulus(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    rst_n = 1'b1;
    sampleAt("tear_mid", 44);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    sampleAt("tear_same", 60);
    checkOutput("tear_keeps_one", 4'h7, 7'h79, 1'b1);
    sampleAt("tear_next", 92);
    checkOutput("tear_shows_nine", 4'h7, 7'h10, 1'b1);

    $display("[TB] scenario 5: invalid digit and decimal points");
    applyReset(2);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'hC, 1'b1, 4'b0101);
    rst_n = 1'b1;
    sampleAt("inv_d0", 36);
    checkOutput("inv_d0_dash", 4'hE, 7'h3F, 1'b0);
    sampleAt("inv_d1", 44);
    checkOutput("inv_d1", 4'hD, 7'h7F, 1'b1);
    sampleAt("inv_d2_dead", 48);
    checkOutput("inv_d2_dead_dp", 4'hF, 7'h7F, 1'b0);
    sampleAt("inv_d2", 52);
    checkOutput("inv_d2", 4'hB, 7'h7F, 1'b0);
    sampleAt("inv_d3", 60);
    checkOutput("inv_d3", 4'h7, 7'h7F, 1'b1);

    $display("[TB] scenario 6: mid-frame reset");
    sampleAt("mid_idx2", 83);
    checkOutput("pre_reset_idx2", 4'hB, 7'h7F, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_off", 4'hF, 7'h7F, 1'b1);
    rst_n = 1'b1;
    sampleAt("post_d0", 4);
    checkOutput("post_reset_zero", 4'hE, 7'h40, 1'b1);
    sampleAt("post_d3", 28);
    checkOutput("post_reset_d3", 4'h7, 7'h40, 1'b1);
    sampleAt("post_f1", 36);
    checkOutput("post_reset_f1_dash", 4'hE, 7'h3F, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
